shake_arbiter: RTL and testbench

Shares one `keccak_top` SHAKE core between several hash clients, for example the FixedWeight error generator, the session-key hash and the confirmation hash in encapsulation/decapsulation.
- Grants the core to one requester for a whole hash session using round-robin order.
- Routes that requester's streaming handshake to and from the core.
- Flushes the core with a one-cycle `force_done` pulse when the session ends, so each client sees a clean core.
- Sits between the `*_seq_gen` sequencers and the single `keccak_top` instance.

---
 rtl/shake_arbiter_pkg.sv | 21 ++
 rtl/shake_arbiter_rr_pick.sv | 48 ++++
 rtl/shake_arbiter.sv | 139 +++++++++++++
 tb/tb_shake_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/shake_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shake_arbiter_pkg
// Description : Shared definitions for the SHAKE core arbiter: FSM state
//               encoding and the default core data width.
// Revision    : 1.0 - initial release
// ============================================================================
package shake_arbiter_pkg;

    // Data word width of the keccak_top streaming interface.
    localparam int SHAKE_W = 32;

    // Arbiter session states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/shake_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Searches req upward from
//               last+1 with wrap-around and returns the first set bit.
// Ports       : req      - request vector
//               last     - index of the previous winner
//               pick     - one-hot winner (zero when req is zero)
//               pick_idx - binary index of the winner
//               any      - high when at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               any
);

    logic             w_found;
    logic [IDX_W-1:0] w_pos;

    assign any = |req;

    // Offsets 1..NUM_REQ visit every client once, ending with last itself,
    // so the previous winner has the lowest priority.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        w_found  = 1'b0;
        w_pos    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!w_found && req[w_pos]) begin
                w_found       = 1'b1;
                pick          = '0;
                pick[w_pos]   = 1'b1;
                pick_idx      = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shake_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : shake_arbiter
// Description : Shares one keccak_top SHAKE core between NUM_REQ hash
//               clients. A client holds the core for a whole session
//               (while its req is high); sessions are granted round-robin and
//               every session ends with a one-cycle force_done flush.
// Ports       : clk, rst                 - clock, async active-high reset
//               req / gnt                - session request / one-hot grant
//               din_*_req, dout_*_req    - per-client streaming handshakes
//               force_done_req           - per-client early terminate
//               *_shake                  - single core-side interface
//               busy                     - high in GRANT or FLUSH
// Revision    : 1.0 - initial release
// ============================================================================
module shake_arbiter
    import shake_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int W       = SHAKE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    input  logic [NUM_REQ-1:0]   din_valid_req,
    input  logic [NUM_REQ*W-1:0] din_req,
    output logic [NUM_REQ-1:0]   din_ready_req,
    output logic [NUM_REQ-1:0]   dout_valid_req,
    input  logic [NUM_REQ-1:0]   dout_ready_req,
    output logic [W-1:0]         dout_req,
    input  logic [NUM_REQ-1:0]   force_done_req,
    output logic                 din_valid_shake,
    output logic [W-1:0]         din_shake,
    input  logic                 din_ready_shake,
    input  logic                 dout_valid_shake,
    input  logic [W-1:0]         dout_shake,
    output logic                 dout_ready_shake,
    output logic                 force_done_shake,
    output logic                 busy
);

    localparam int               IDX_W      = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0]   r_last;       // doubles as the granted index in GRANT
    logic [IDX_W-1:0]   w_last_nxt;

    logic [NUM_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_any;

    logic [W-1:0]       w_din_words [NUM_REQ];

    // Split the flat client data bus into words for the routing mux.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_din_words[i] = din_req[i*W +: W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .last     (r_last),
        .pick     (w_pick),
        .pick_idx (w_pick_idx),
        .any      (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_last  <= C_LAST_RST;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next state plus routing. Outputs decode from the registered state so
    // an asynchronous reset silences every routed signal at once.
    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = r_gnt;
        w_last_nxt       = r_last;
        din_valid_shake  = 1'b0;
        din_shake        = '0;
        dout_ready_shake = 1'b0;
        force_done_shake = 1'b0;
        din_ready_req    = '0;
        dout_valid_req   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_last_nxt  = w_pick_idx;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                din_valid_shake        = din_valid_req[r_last];
                din_shake              = w_din_words[r_last];
                dout_ready_shake       = dout_ready_req[r_last];
                force_done_shake       = force_done_req[r_last];
                din_ready_req[r_last]  = din_ready_shake;
                dout_valid_req[r_last] = dout_valid_shake;
                // Any handshake in flight when req drops is simply abandoned.
                if (!req[r_last]) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                force_done_shake = 1'b1;
                w_state_nxt      = ST_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gnt      = r_gnt;
    assign busy     = (r_state != ST_IDLE);
    assign dout_req = dout_shake;

endmodule
`default_nettype wire

// File: tb/tb_shake_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_shake_arbiter
// Description : Directed self-checking bench for shake_arbiter (NUM_REQ=2).
//               The core side is driven directly by the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shake_arbiter;

    localparam int NUM_REQ = 2;
    localparam int W       = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   din_valid_req;
    logic [NUM_REQ*W-1:0] din_req;
    logic [NUM_REQ-1:0]   din_ready_req;
    logic [NUM_REQ-1:0]   dout_valid_req;
    logic [NUM_REQ-1:0]   dout_ready_req;
    logic [W-1:0]         dout_req;
    logic [NUM_REQ-1:0]   force_done_req;
    logic                 din_valid_shake;
    logic [W-1:0]         din_shake;
    logic                 din_ready_shake;
    logic                 dout_valid_shake;
    logic [W-1:0]         dout_shake;
    logic                 dout_ready_shake;
    logic                 force_done_shake;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shake_arbiter #(
        .NUM_REQ (NUM_REQ),
        .W       (W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .gnt              (gnt),
        .din_valid_req    (din_valid_req),
        .din_req          (din_req),
        .din_ready_req    (din_ready_req),
        .dout_valid_req   (dout_valid_req),
        .dout_ready_req   (dout_ready_req),
        .dout_req         (dout_req),
        .force_done_req   (force_done_req),
        .din_valid_shake  (din_valid_shake),
        .din_shake        (din_shake),
        .din_ready_shake  (din_ready_shake),
        .dout_valid_shake (dout_valid_shake),
        .dout_shake       (dout_shake),
        .dout_ready_shake (dout_ready_shake),
        .force_done_shake (force_done_shake),
        .busy             (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Everything routed towards clients or core must be idle.
    task automatic chk_quiet(input string tag);
        chk({tag, ".din_valid_shake"},  din_valid_shake,  1'b0);
        chk({tag, ".din_shake"},        din_shake,        '0);
        chk({tag, ".dout_ready_shake"}, dout_ready_shake, 1'b0);
        chk({tag, ".din_ready_req"},    din_ready_req,    '0);
        chk({tag, ".dout_valid_req"},   dout_valid_req,   '0);
    endtask

    initial begin
        int h;
        int e;
        logic [NUM_REQ-1:0] exp_g;

        rst              = 1'b1;
        req              = '0;
        din_valid_req    = '0;
        din_req          = '0;
        dout_ready_req   = '0;
        force_done_req   = '0;
        din_ready_shake  = 1'b0;
        dout_valid_shake = 1'b0;
        dout_shake       = 32'hA5A5_0001;
        #3;

        // ---- reset values ----
        chk("rst.gnt",  gnt,  2'b00);
        chk("rst.busy", busy, 1'b0);
        chk("rst.fds",  force_done_shake, 1'b0);
        chk("rst.dout_req", dout_req, 32'hA5A5_0001);
        chk_quiet("rst");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---- single client session ----
        req = 2'b01;
        #1;
        chk("s1.no_comb_gnt", gnt, 2'b00);
        tick();
        chk("s1.gnt",  gnt,  2'b01);
        chk("s1.busy", busy, 1'b1);
        din_valid_req    = 2'b01;
        din_req          = {32'h2222_2222, 32'h1111_1111};
        din_ready_shake  = 1'b1;
        dout_valid_shake = 1'b1;
        dout_ready_req   = 2'b01;
        #1;
        chk("s1.din_valid_shake",  din_valid_shake,  1'b1);
        chk("s1.din_shake",        din_shake,        32'h1111_1111);
        chk("s1.din_ready_req",    din_ready_req,    2'b01);
        chk("s1.dout_valid_req",   dout_valid_req,   2'b01);
        chk("s1.dout_ready_shake", dout_ready_shake, 1'b1);
        for (int i = 0; i < 4; i++) begin
            din_req[31:0] = 32'hC0DE_0000 + i;
            dout_shake    = 32'hD0D0_0000 + i;
            #1;
            chk("s1.word", din_shake, 32'hC0DE_0000 + i);
            chk("s1.dout_req", dout_req, 32'hD0D0_0000 + i);
            tick();
        end
        // early-terminate pass-through, grant unaffected
        force_done_req = 2'b01;
        #1;
        chk("fd.pass", force_done_shake, 1'b1);
        tick();
        force_done_req = 2'b00;
        #1;
        chk("fd.gnt_kept", gnt, 2'b01);
        chk("fd.low",      force_done_shake, 1'b0);
        // release with a word still pending
        req = 2'b00;
        tick();
        chk("rel.flush_fds",  force_done_shake, 1'b1);
        chk("rel.flush_gnt",  gnt,  2'b00);
        chk("rel.flush_busy", busy, 1'b1);
        chk_quiet("rel.flush");
        tick();
        chk("rel.idle_fds",  force_done_shake, 1'b0);
        chk("rel.idle_busy", busy, 1'b0);
        din_valid_req  = '0;
        dout_ready_req = '0;

        // ---- contention after reset: client 0 first ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b11;
        tick();
        chk("ct.gnt0", gnt, 2'b01);
        req = 2'b10;
        tick();
        chk("ct.c1_flush", gnt, 2'b00);
        tick();
        chk("ct.c2_idle", gnt, 2'b00);
        tick();
        chk("ct.c3_gnt1", gnt, 2'b10);

        // ---- client 1 streams, client 0 toggles valid ----
        din_req = {32'hBEEF_0001, 32'h0BAD_0000};
        for (int i = 0; i < 4; i++) begin
            din_valid_req = {1'b1, 1'(i)};
            #1;
            chk("iso.dvs",   din_valid_shake, 1'b1);
            chk("iso.ready", din_ready_req,   2'b10);
            chk("iso.data",  din_shake,       32'hBEEF_0001);
            tick();
        end
        din_valid_req = 2'b01;
        #1;
        chk("iso.dvs_c0only", din_valid_shake, 1'b0);
        chk("iso.ready_c0",   din_ready_req,   2'b10);
        din_valid_req = '0;

        // ---- back-to-back re-requests: 0,1,0,1 ----
        req = 2'b11;
        h   = 1;
        for (int r = 0; r < 4; r++) begin
            e = (r % 2 == 0) ? 0 : 1;
            req[h] = 1'b0;
            tick();
            req[h] = 1'b1;
            tick();
            tick();
            exp_g    = '0;
            exp_g[e] = 1'b1;
            chk("b2b.gnt", gnt, exp_g);
            h = e;
        end

        // ---- asynchronous reset mid-session ----
        dout_ready_req = 2'b10;
        #1;
        chk("ar.pre_dout_valid", dout_valid_req, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.gnt",  gnt,  2'b00);
        chk("ar.busy", busy, 1'b0);
        chk("ar.fds",  force_done_shake, 1'b0);
        chk_quiet("ar");
        tick();
        chk("ar.no_flush", force_done_shake, 1'b0);
        rst = 1'b0;
        tick();
        chk("ar.first_gnt", gnt, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
